return_address_stack: RTL and testbench

- Circular hardware stack holding predicted return addresses for the single-cycle RISC-V core.
- Calls (JAL/JALR with rd = x1/x5) push the link value PC+4 computed by the PC adder. Returns pop it.
- Runs in the opposite direction to next-PC generation: it recovers earlier PCs instead of advancing.
- Sits beside the PC select mux in fetch. o_top_addr is the predicted target for returns.

---
 rtl/return_address_stack.sv | 112 +++++++++++
 tb/tb_return_address_stack.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/return_address_stack.sv
// Circular return-address stack for fetch-stage return prediction.
// Optional {tos,count} checkpoint/restore is enabled by defining RAS_CHECKPOINT_EN.
module return_address_stack #(
  parameter  int DATA_WIDTH = 64,
  parameter  int DEPTH      = 8,
  localparam int PTR_W      = $clog2(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_push_addr,
  input  logic                  i_pop,
`ifdef RAS_CHECKPOINT_EN
  input  logic                  i_ckpt_save,
  input  logic                  i_ckpt_restore,
`endif
  output logic [DATA_WIDTH-1:0] o_top_addr,
  output logic                  o_top_valid,
  output logic                  o_empty,
  output logic                  o_full,
  output logic [PTR_W:0]        o_count,
  output logic                  o_overflow,
  output logic                  o_underflow
);

  localparam logic [PTR_W:0]   FULL_CNT = DEPTH[PTR_W:0];
  localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] entry [DEPTH];
  logic [PTR_W-1:0]      tos, tos_n, wr_ptr;
  logic [PTR_W:0]        count, count_n;
  logic                  ovf_n, unf_n, wr_en;

`ifdef RAS_CHECKPOINT_EN
  logic [PTR_W-1:0] snap_tos;
  logic [PTR_W:0]   snap_count;
`endif

  always_comb begin
    tos_n   = tos;
    count_n = count;
    ovf_n   = 1'b0;
    unf_n   = 1'b0;
    wr_en   = 1'b0;
    wr_ptr  = tos;
    // With entries present, push+pop replaces the top in place; from empty it degrades to a plain push.
    if (i_push && !(i_pop && count != '0)) begin
      tos_n  = tos + PTR_ONE;
      wr_ptr = tos + PTR_ONE;
      wr_en  = 1'b1;
      if (count == FULL_CNT) ovf_n = !i_pop;
      else                   count_n = count + 1'b1;
    end else if (i_push) begin
      wr_en = 1'b1;
    end else if (i_pop) begin
      if (count != '0) begin
        tos_n   = tos - PTR_ONE;
        count_n = count - 1'b1;
      end else begin
        unf_n = 1'b1;
      end
    end
`ifdef RAS_CHECKPOINT_EN
    if (i_ckpt_restore) begin
      tos_n   = snap_tos;
      count_n = snap_count;
      ovf_n   = 1'b0;
      unf_n   = 1'b0;
      wr_en   = 1'b0;
    end
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tos         <= '0;
      count       <= '0;
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      tos         <= tos_n;
      count       <= count_n;
      o_overflow  <= ovf_n;
      o_underflow <= unf_n;
    end
  end

  // Storage is not reset; only the pointer and count define validity.
  always_ff @(posedge i_clk) begin
    if (wr_en && !i_rst) entry[wr_ptr] <= i_push_addr;
  end

`ifdef RAS_CHECKPOINT_EN
  // Save alongside restore keeps the old snapshot, which equals the restored state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      snap_tos   <= '0;
      snap_count <= '0;
    end else if (i_ckpt_save && !i_ckpt_restore) begin
      snap_tos   <= tos;
      snap_count <= count;
    end
  end
`endif

  assign o_top_addr  = entry[tos];
  assign o_top_valid = (count != '0);
  assign o_empty     = (count == '0);
  assign o_full      = (count == FULL_CNT);
  assign o_count     = count;

endmodule

// File: tb/tb_return_address_stack.sv
// Directed self-checking bench for return_address_stack (DEPTH=8, DATA_WIDTH=64).
module tb_return_address_stack;

  logic        clk = 1'b0;
  logic        rst, push, pop;
  logic [63:0] push_addr;
  logic [63:0] top;
  logic        top_valid, empty, full, ovf, unf;
  logic [3:0]  cnt;
`ifdef RAS_CHECKPOINT_EN
  logic        save, restore;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  return_address_stack #(.DATA_WIDTH(64), .DEPTH(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_push(push), .i_push_addr(push_addr), .i_pop(pop),
`ifdef RAS_CHECKPOINT_EN
    .i_ckpt_save(save), .i_ckpt_restore(restore),
`endif
    .o_top_addr(top), .o_top_valid(top_valid), .o_empty(empty), .o_full(full),
    .o_count(cnt), .o_overflow(ovf), .o_underflow(unf)
  );

  task automatic cyc(input logic r, input logic pu, input logic po, input logic [63:0] a);
    rst = r; push = pu; pop = po; push_addr = a;
    @(posedge clk); #1;
    rst = 1'b0; push = 1'b0; pop = 1'b0; push_addr = '0;
  endtask

  task automatic test_reset;
    cyc(1, 0, 0, 0);
    n_vec++; if (cnt !== 4'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", cnt); end
    n_vec++; if (empty !== 1'b1 || top_valid !== 1'b0 || full !== 1'b0) begin n_err++; $display("FAIL reset_flags: empty=%b valid=%b full=%b want 1 0 0", empty, top_valid, full); end
    n_vec++; if (ovf !== 1'b0 || unf !== 1'b0) begin n_err++; $display("FAIL reset_pulses: ovf=%b unf=%b want 0 0", ovf, unf); end
  endtask

  task automatic test_push_pop;
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 64'h1004);
    n_vec++; if (top !== 64'h1004 || top_valid !== 1'b1) begin n_err++; $display("FAIL push1_top: got %h valid=%b want 1004 1", top, top_valid); end
    cyc(0, 1, 0, 64'h2008);
    cyc(0, 1, 0, 64'h300C);
    n_vec++; if (cnt !== 4'd3) begin n_err++; $display("FAIL push3_count: got %0d want 3", cnt); end
    n_vec++; if (top !== 64'h300C) begin n_err++; $display("FAIL push3_top: got %h want 300c", top); end
    cyc(0, 0, 1, 0);
    n_vec++; if (top !== 64'h2008) begin n_err++; $display("FAIL pop_top: got %h want 2008", top); end
    n_vec++; if (cnt !== 4'd2) begin n_err++; $display("FAIL pop_count: got %0d want 2", cnt); end
  endtask

  task automatic test_overflow;
    logic [63:0] exp;
    cyc(1, 0, 0, 0);
    for (int i = 1; i <= 8; i++) cyc(0, 1, 0, 64'(i * 'h100));
    n_vec++; if (cnt !== 4'd8 || full !== 1'b1 || ovf !== 1'b0) begin n_err++; $display("FAIL fill8: count=%0d full=%b ovf=%b want 8 1 0", cnt, full, ovf); end
    cyc(0, 1, 0, 64'h900);
    n_vec++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_pulse: got %b want 1", ovf); end
    n_vec++; if (cnt !== 4'd8 || full !== 1'b1) begin n_err++; $display("FAIL ovf_count: count=%0d full=%b want 8 1", cnt, full); end
    cyc(0, 0, 0, 0);
    n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %b want 0", ovf); end
    for (int i = 9; i >= 2; i--) begin
      exp = 64'(i * 'h100);
      n_vec++; if (top !== exp) begin n_err++; $display("FAIL drain_top%0d: got %h want %h", i, top, exp); end
      cyc(0, 0, 1, 0);
    end
    n_vec++; if (empty !== 1'b1 || cnt !== 4'd0 || unf !== 1'b0) begin n_err++; $display("FAIL drain_empty: empty=%b count=%0d unf=%b want 1 0 0", empty, cnt, unf); end
  endtask

  task automatic test_underflow;
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 0);
    n_vec++; if (unf !== 1'b1) begin n_err++; $display("FAIL unf_pulse: got %b want 1", unf); end
    n_vec++; if (cnt !== 4'd0 || empty !== 1'b1) begin n_err++; $display("FAIL unf_count: count=%0d empty=%b want 0 1", cnt, empty); end
    cyc(0, 1, 0, 64'hA0);
    n_vec++; if (unf !== 1'b0) begin n_err++; $display("FAIL unf_clear: got %b want 0", unf); end
    n_vec++; if (top !== 64'hA0 || cnt !== 4'd1) begin n_err++; $display("FAIL unf_push: top=%h count=%0d want a0 1", top, cnt); end
    cyc(0, 0, 1, 0);
    n_vec++; if (cnt !== 4'd0 || unf !== 1'b0) begin n_err++; $display("FAIL unf_repop: count=%0d unf=%b want 0 0", cnt, unf); end
  endtask

  task automatic test_push_pop_same;
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 64'h1004);
    cyc(0, 1, 0, 64'h2008);
    cyc(0, 1, 1, 64'h4444);
    n_vec++; if (top !== 64'h4444 || cnt !== 4'd2) begin n_err++; $display("FAIL swap_top: top=%h count=%0d want 4444 2", top, cnt); end
    n_vec++; if (ovf !== 1'b0 || unf !== 1'b0) begin n_err++; $display("FAIL swap_pulses: ovf=%b unf=%b want 0 0", ovf, unf); end
    cyc(0, 0, 1, 0);
    n_vec++; if (top !== 64'h1004) begin n_err++; $display("FAIL swap_below: got %h want 1004", top); end
    cyc(1, 0, 0, 0);
    cyc(0, 1, 1, 64'h55);
    n_vec++; if (cnt !== 4'd1 || top !== 64'h55) begin n_err++; $display("FAIL swap_empty: count=%0d top=%h want 1 55", cnt, top); end
    n_vec++; if (ovf !== 1'b0 || unf !== 1'b0) begin n_err++; $display("FAIL swap_empty_pulses: ovf=%b unf=%b want 0 0", ovf, unf); end
    // full stack: push+pop replaces top without overflow
    for (int i = 0; i < 7; i++) cyc(0, 1, 0, 64'(i + 1));
    cyc(0, 1, 1, 64'hBEEF);
    n_vec++; if (cnt !== 4'd8 || top !== 64'hBEEF || ovf !== 1'b0) begin n_err++; $display("FAIL swap_full: count=%0d top=%h ovf=%b want 8 beef 0", cnt, top, ovf); end
  endtask

  task automatic test_reset_priority;
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 64'h10);
    cyc(0, 1, 0, 64'h20);
    cyc(1, 1, 0, 64'h30);
    n_vec++; if (cnt !== 4'd0 || empty !== 1'b1 || top_valid !== 1'b0) begin n_err++; $display("FAIL rstpri_state: count=%0d empty=%b valid=%b want 0 1 0", cnt, empty, top_valid); end
    n_vec++; if (ovf !== 1'b0 || unf !== 1'b0) begin n_err++; $display("FAIL rstpri_pulses: ovf=%b unf=%b want 0 0", ovf, unf); end
    cyc(0, 1, 0, 64'h40);
    n_vec++; if (cnt !== 4'd1 || top !== 64'h40) begin n_err++; $display("FAIL rstpri_push: count=%0d top=%h want 1 40", cnt, top); end
  endtask

`ifdef RAS_CHECKPOINT_EN
  task automatic test_checkpoint;
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 64'h10);
    save = 1'b1; cyc(0, 0, 0, 0); save = 1'b0;
    cyc(0, 1, 0, 64'h20);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    n_vec++; if (cnt !== 4'd0) begin n_err++; $display("FAIL ckpt_drained: got %0d want 0", cnt); end
    restore = 1'b1; cyc(0, 1, 1, 64'h99); restore = 1'b0;
    n_vec++; if (cnt !== 4'd1 || top !== 64'h10) begin n_err++; $display("FAIL ckpt_restore: count=%0d top=%h want 1 10", cnt, top); end
    n_vec++; if (ovf !== 1'b0 || unf !== 1'b0) begin n_err++; $display("FAIL ckpt_pulses: ovf=%b unf=%b want 0 0", ovf, unf); end
  endtask
`endif

  initial begin
    rst = 1'b1; push = 1'b0; pop = 1'b0; push_addr = '0;
`ifdef RAS_CHECKPOINT_EN
    save = 1'b0; restore = 1'b0;
`endif
    test_reset();
    test_push_pop();
    test_overflow();
    test_underflow();
    test_push_pop_same();
    test_reset_priority();
`ifdef RAS_CHECKPOINT_EN
    test_checkpoint();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
